add16_vector_checker: RTL and testbench

- Synthesizable on-chip self-checker for the `Add16` adder.
- Streams packed test vectors `{a, b, sum_expected}` from a synchronous ROM and drives `a`/`b` into a combinational `Add16` instance.
- After a settle interval, samples the adder's `sum`, compares it with the expected value, and reports a pass/fail summary.
- Hardware counterpart of the simulation vector bench; used for on-board regression of the chapter-2 arithmetic chips.

---
 rtl/add16_vector_checker.sv | 106 ++++++++++
 tb/tb_add16_vector_checker.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/add16_vector_checker.sv
// rtl/add16_vector_checker.sv - on-chip vector checker for the Add16 adder
// Streams {a, b, sum_expected} words from a 1-cycle ROM, compares sum, reports pass/fail.
module add16_vector_checker #(
  parameter int NUM_VECTORS = 6,
  parameter int ADDR_W      = 3,
  parameter int SETTLE      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [47:0]       vec_data,
  output logic [15:0]       a,
  output logic [15:0]       b,
  input  logic [15:0]       sum,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        fail_count,
  output logic [ADDR_W-1:0] first_fail_idx
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       expected;
  logic [CNT_W-1:0]  settle_cnt;
  logic              mismatch;

  assign mismatch = (sum != expected);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      vec_addr       <= '0;
      a              <= '0;
      b              <= '0;
      expected       <= '0;
      settle_cnt     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            fail_count     <= '0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b1;
            idx            <= '0;
            vec_addr       <= '0;
            state          <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          a          <= vec_data[47:32];
          b          <= vec_data[31:16];
          expected   <= vec_data[15:0];
          settle_cnt <= '0;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= ST_CHECK;
          else                           settle_cnt <= settle_cnt + 1'b1;
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
            // fail_count saturates and never returns to zero, so zero marks the first miss
            if (fail_count == 8'd0) first_fail_idx <= idx;
          end
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mismatch && (fail_count == 8'd0);
            state <= ST_DONE;
          end else begin
            idx      <= idx + 1'b1;
            vec_addr <= idx + 1'b1;
            state    <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add16_vector_checker.sv
// tb/tb_add16_vector_checker.sv - directed bench for add16_vector_checker
// Behavioral 1-cycle ROM and a 16-bit adder drive the checker through its run scenarios.
module tb_add16_vector_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  vec_addr;
  logic [47:0] vec_data;
  logic [15:0] a, b, sum;
  logic        busy, done, pass;
  logic [7:0]  fail_count;
  logic [2:0]  first_fail_idx;

  logic [47:0] rom [0:7];
  int          errors = 0;
  int          checks = 0;
  int          cyc;

  always #5 clk = ~clk;

  always_ff @(posedge clk) vec_data <= rom[vec_addr];
  assign sum = a + b;

  add16_vector_checker #(.NUM_VECTORS(6), .ADDR_W(3), .SETTLE(1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .vec_addr(vec_addr), .vec_data(vec_data),
    .a(a), .b(b), .sum(sum),
    .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail_idx(first_fail_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_pass_rom();
    rom[0] = {16'h0000, 16'h0000, 16'h0000};
    rom[1] = {16'h0001, 16'h0001, 16'h0002};
    rom[2] = {16'hFFFF, 16'h0001, 16'h0000};
    rom[3] = {16'h1234, 16'h4321, 16'h5555};
    rom[4] = {16'hAAAA, 16'h5555, 16'hFFFF};
    rom[5] = {16'hFFFF, 16'hFFFF, 16'hFFFE};
    rom[6] = 48'h0;
    rom[7] = 48'h0;
  endtask

  // Leaves the bench at the negedge following the edge that samples start (cyc = 0).
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_done();
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (busy && done) check("busy_done_overlap", 1, 0);
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vec_addr"}, 32'(vec_addr), 0);
    check({tag, "_a"}, 32'(a), 0);
    check({tag, "_b"}, 32'(b), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_fail_count"}, 32'(fail_count), 0);
    check({tag, "_first_fail_idx"}, 32'(first_fail_idx), 0);
  endtask

  initial begin
    load_pass_rom();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("reset");

    // 1: all-pass run
    pulse_start();
    check("t1_busy_after_start", 32'(busy), 1);
    wait_done();
    check("t1_cycles", cyc, 24);
    check("t1_pass", 32'(pass), 1);
    check("t1_fail_count", 32'(fail_count), 0);
    check("t1_first_fail_idx", 32'(first_fail_idx), 0);
    check("t1_busy_low", 32'(busy), 0);

    // 2: single corrupt vector
    rom[3][15:0] = 16'h5556;
    pulse_start();
    wait_done();
    check("t2_cycles", cyc, 24);
    check("t2_fail_count", 32'(fail_count), 1);
    check("t2_first_fail_idx", 32'(first_fail_idx), 3);
    check("t2_pass", 32'(pass), 0);

    // 3: all expected values inverted
    load_pass_rom();
    for (int i = 0; i < 6; i++) rom[i][15:0] = ~rom[i][15:0];
    pulse_start();
    wait_done();
    check("t3_fail_count", 32'(fail_count), 6);
    check("t3_first_fail_idx", 32'(first_fail_idx), 0);
    check("t3_pass", 32'(pass), 0);

    // 4: start pulses while busy are ignored; address held 4 cycles each
    load_pass_rom();
    pulse_start();
    while (!done && cyc < 200) begin
      if (cyc < 24) check($sformatf("t4_vec_addr_c%0d", cyc), 32'(vec_addr), cyc / 4);
      start = (cyc == 5 || cyc == 12);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("t4_cycles", cyc, 24);
    check("t4_pass", 32'(pass), 1);

    // 5: reset mid-run
    pulse_start();
    repeat (10) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("t5");
    @(negedge clk);
    check("t5_idle_busy", 32'(busy), 0);
    pulse_start();
    wait_done();
    check("t5_cycles", cyc, 24);
    check("t5_pass", 32'(pass), 1);

    // 6: restart from DONE after a failing run
    rom[1][15:0] = 16'h0003;
    pulse_start();
    wait_done();
    check("t6_fail_run_count", 32'(fail_count), 1);
    check("t6_fail_run_idx", 32'(first_fail_idx), 1);
    load_pass_rom();
    pulse_start();
    check("t6_done_dropped", 32'(done), 0);
    check("t6_fail_count_cleared", 32'(fail_count), 0);
    check("t6_busy", 32'(busy), 1);
    wait_done();
    check("t6_cycles", cyc, 24);
    check("t6_pass", 32'(pass), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
